// File: rtl/argmax_layer_if.sv
// Handshake and data bundle between an argmax requester and the argmax_layer scanner.
// The master side drives the start request and activations. The slave side returns the result.
interface argmax_layer_if #(
    parameter int NEURON_NB = 10,
    parameter int WIDTH     = 32,
    parameter int IDX_W     = (NEURON_NB > 1) ? $clog2(NEURON_NB) : 1
);
    logic                         argmax_go;
    logic [WIDTH*NEURON_NB-1:0]   data_in_array;
    logic                         argmax_done;
    logic [IDX_W-1:0]             max_index;
    logic [WIDTH-1:0]             max_value;

    modport master (
        output argmax_go,
        output data_in_array,
        input  argmax_done,
        input  max_index,
        input  max_value
    );

    modport slave (
        input  argmax_go,
        input  data_in_array,
        output argmax_done,
        output max_index,
        output max_value
    );
endinterface

// File: rtl/argmax_layer.sv
// Sequential argmax: snapshots NEURON_NB unsigned activations on go, then compares one per cycle.
// The result (lowest index on ties) is presented with a level done flag NEURON_NB edges after go.
module argmax_layer #(
    parameter int NEURON_NB = 10,
    parameter int WIDTH     = 32,
    parameter int IDX_W     = (NEURON_NB > 1) ? $clog2(NEURON_NB) : 1
) (
    input  logic          clk,
    input  logic          reset,
    argmax_layer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NEURON_NB - 1);
    localparam logic [IDX_W-1:0] FIRST_CMP = IDX_W'((NEURON_NB > 1) ? 1 : 0);
    localparam logic             SKIP_CMP  = (NEURON_NB == 1);

    state_t             state_reg;
    state_t             state_next;

    logic [WIDTH-1:0]   data_elem [NEURON_NB];
    logic [WIDTH-1:0]   snap_reg  [NEURON_NB];

    logic [IDX_W-1:0]   cnt_reg;
    logic               cmp_done_reg;
    logic [WIDTH-1:0]   cand_val_reg;
    logic [IDX_W-1:0]   cand_idx_reg;
    logic               done_reg;
    logic [IDX_W-1:0]   max_index_reg;
    logic [WIDTH-1:0]   max_value_reg;

    logic               accept;
    logic               compare_en;
    logic               finish;
    logic [WIDTH-1:0]   scan_elem;
    logic               elem_greater;

    // Unpack the flat activation bus and hold a private copy per element.
    generate
        for (genvar gi = 0; gi < NEURON_NB; gi++) begin : g_elem
            assign data_elem[gi] = bus.data_in_array[(gi+1)*WIDTH-1 -: WIDTH];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    snap_reg[gi] <= '0;
                end else if (accept) begin
                    snap_reg[gi] <= data_elem[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // SCAN spends one edge per compare, then one extra edge to publish the result,
    // which yields exactly NEURON_NB edges from go to done.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        compare_en = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.argmax_go) begin
                    accept     = 1'b1;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (cmp_done_reg) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end else begin
                    compare_en = 1'b1;
                end
            end
            DONE: begin
                if (bus.argmax_go) begin
                    accept     = 1'b1;
                    state_next = SCAN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        scan_elem = '0;
        for (int i = 0; i < NEURON_NB; i++) begin
            if (cnt_reg == IDX_W'(i)) begin
                scan_elem = snap_reg[i];
            end
        end
    end

    // Strictly greater keeps the earliest index on ties.
    assign elem_greater = (scan_elem > cand_val_reg);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg       <= '0;
            cmp_done_reg  <= 1'b0;
            cand_val_reg  <= '0;
            cand_idx_reg  <= '0;
            done_reg      <= 1'b0;
            max_index_reg <= '0;
            max_value_reg <= '0;
        end else begin
            if (accept) begin
                cand_val_reg <= data_elem[0];
                cand_idx_reg <= '0;
                cnt_reg      <= FIRST_CMP;
                cmp_done_reg <= SKIP_CMP;
                done_reg     <= 1'b0;
            end
            if (compare_en) begin
                if (elem_greater) begin
                    cand_val_reg <= scan_elem;
                    cand_idx_reg <= cnt_reg;
                end
                // Counter parks on the last index; the flag ends the scan instead of a wrap.
                if (cnt_reg == LAST_IDX) begin
                    cmp_done_reg <= 1'b1;
                end else begin
                    cnt_reg <= cnt_reg + IDX_W'(1);
                end
            end
            if (finish) begin
                max_index_reg <= cand_idx_reg;
                max_value_reg <= cand_val_reg;
                done_reg      <= 1'b1;
            end
        end
    end

    assign bus.argmax_done = done_reg;
    assign bus.max_index   = max_index_reg;
    assign bus.max_value   = max_value_reg;

endmodule

// File: doc/argmax_layer.md
ARGMAX_LAYER -- requirements
Module: argmax_layer

Interface
REQ-001 The block SHALL have parameter NEURON_NB, default 10, number of neuron values scanned per classification.
REQ-002 The block SHALL have parameter WIDTH, default 32, bit width of each neuron value.
REQ-003 The block SHALL have parameter IDX_W, default $clog2(NEURON_NB) with minimum 1, width of the result index.
REQ-004 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port argmax_go  input  1  start request, sampled on the rising edge of clk.
REQ-007 The block SHALL have port data_in_array  input  WIDTH*NEURON_NB  flattened unsigned activations; element i occupies bits [(i+1)*WIDTH-1 -: WIDTH].
REQ-008 The block SHALL have port argmax_done  output  1  result valid flag.
REQ-009 The block SHALL have port max_index  output  IDX_W  index of the largest element.
REQ-010 The block SHALL have port max_value  output  WIDTH  value of the largest element.

Function
REQ-011 The block SHALL implement FSM states IDLE, SCAN and DONE.
REQ-012 In IDLE or DONE, argmax_go=1 at a rising edge SHALL trigger three actions: capture all of data_in_array into an internal snapshot register, load candidate value/index with element 0/0, and enter SCAN.
REQ-013 The block SHALL leave argmax_done at 0 from the edge that accepts argmax_go until the edge that enters DONE.
REQ-014 In SCAN, the block SHALL compare exactly one snapshot element per cycle, for elements 1 to NEURON_NB-1 in ascending order.
REQ-015 Comparison SHALL be unsigned and full WIDTH; the candidate SHALL be replaced only when the element is strictly greater, so ties resolve to the lowest index.
REQ-016 After the last element is compared, the block SHALL enter DONE, drive max_index/max_value from the final candidate, and set argmax_done=1; this occurs NEURON_NB rising edges after the go-accepting edge.
REQ-017 For NEURON_NB=1, the block SHALL skip SCAN comparisons and enter DONE one edge after go, with max_index=0.
REQ-018 argmax_done SHALL be a level, held at 1 in DONE until the next accepted argmax_go.
REQ-019 max_index and max_value SHALL change only on the edge entering DONE, and SHALL hold their previous result while SCAN is in progress.
REQ-020 argmax_go asserted during SCAN SHALL be ignored, with no restart and no snapshot update.
REQ-021 Changes on data_in_array after the go-accepting edge SHALL NOT affect the result.
REQ-022 argmax_go held continuously high SHALL restart a new scan on each DONE entry-plus-one edge, so that argmax_done is high for exactly one cycle per result.
REQ-023 The scan element counter SHALL be IDX_W bits wide and SHALL NOT wrap within a scan; it SHALL terminate at NEURON_NB-1.

Reset
REQ-024 reset=0 SHALL immediately force all of the following, independent of clk: state=IDLE, argmax_done=0, max_index=0, max_value=0, counter=0, candidate=0 and snapshot=0.
REQ-025 Reset asserted mid-SCAN SHALL abort the scan with no partial result visible; after release, the block SHALL wait in IDLE for argmax_go.
REQ-026 On the first rising edge after reset deasserts, the block SHALL accept argmax_go normally.

Verification
REQ-027 The bench SHALL cover this basic scenario with NEURON_NB=10 and WIDTH=32: elements {5,9,3,0,12,7,1,2,8,4} and a one-cycle go; the required response is argmax_done rising 10 edges later, with max_index=4 and max_value=12.
REQ-028 The bench SHALL cover this tie scenario: elements {0,7,0,7,0,0,0,0,0,7}; the required response is max_index=1 and max_value=7.
REQ-029 The bench SHALL cover this unsigned and all-zero scenario: element 6=32'hFFFF_FFFF with all others 1, giving max_index=6; then all zeros, giving max_index=0 and max_value=0.
REQ-030 The bench SHALL cover this stability scenario: go is accepted, the bench changes data_in_array and pulses go again during SCAN; the required response is a result that matches the original snapshot, done exactly 10 edges after the first go, and no restart.
REQ-031 The bench SHALL cover this reset scenario: reset is asserted 4 cycles into SCAN; the required response is all outputs at 0 immediately and IDLE after release, and a new go then yields a correct result 10 edges later.
REQ-032 The bench SHALL cover this back-to-back scenario: go is held high across two results; the required response is argmax_done high for one cycle every 11 cycles, with each result matching its captured snapshot.
